// File: rtl/divu_hilo.sv
`default_nettype none
// ============================================================================
// Module      : divu_hilo
// Description : Unsigned 32-bit divide unit with HI/LO result registers.
//               A DIVU function code (rising into DIVU) launches a restoring
//               shift-subtract divide of 32 iterations; HI receives the
//               remainder and LO the quotient. MFHI/MFLO select HI/LO onto
//               dataOut combinationally. Divide-by-zero completes at once
//               with HI=dividend, LO=all-ones and dbz set.
// Ports       : clk     - clock, rising edge
//               reset   - asynchronous active-high reset
//               Signal  - 6-bit function code
//               dataA   - dividend (unsigned)
//               dataB   - divisor (unsigned)
//               dataOut - HI/LO read data (0 when not MFHI/MFLO)
//               busy    - high while iterating
//               done    - one-cycle pulse when HI/LO are written
//               dbz     - divide-by-zero flag, valid with done
// Revision    : 1.0 - initial release
// ============================================================================
module divu_hilo #(
  parameter logic [5:0] DIVU = 6'b011011,
  parameter logic [5:0] MFHI = 6'b010000,
  parameter logic [5:0] MFLO = 6'b010010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Signal,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  output logic [31:0] dataOut,
  output logic        busy,
  output logic        done,
  output logic        dbz
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  r_state;
  logic [5:0]  r_prev_signal;
  logic [31:0] r_dividend;
  logic [31:0] r_divisor;
  logic [31:0] r_rem;
  logic [31:0] r_quot;
  logic [4:0]  r_count;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_dbz;

  logic        w_start;
  logic [32:0] w_rem_shift;
  logic        w_ge;
  logic [31:0] w_rem_next;
  logic [31:0] w_quot_next;

  // Only a transition into DIVU starts a divide, so a held code fires once.
  assign w_start = (r_state == IDLE) && (Signal == DIVU) && (r_prev_signal != DIVU);

  // The shifted partial remainder needs 33 bits for the compare. When it is
  // >= divisor the true difference is below 2^32, so a 32-bit subtract of
  // the low bits is exact.
  assign w_rem_shift = {r_rem, r_dividend[31]};
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_next  = w_ge ? (w_rem_shift[31:0] - r_divisor) : w_rem_shift[31:0];
  assign w_quot_next = {r_quot[30:0], w_ge};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_prev_signal <= 6'd0;
      r_dividend    <= 32'd0;
      r_divisor     <= 32'd0;
      r_rem         <= 32'd0;
      r_quot        <= 32'd0;
      r_count       <= 5'd0;
      r_hi          <= 32'd0;
      r_lo          <= 32'd0;
      r_dbz         <= 1'b0;
    end else begin
      r_prev_signal <= Signal;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (dataB == 32'd0) begin
              r_hi    <= dataA;
              r_lo    <= 32'hFFFF_FFFF;
              r_dbz   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_dividend <= dataA;
              r_divisor  <= dataB;
              r_rem      <= 32'd0;
              r_quot     <= 32'd0;
              r_count    <= 5'd0;
              r_state    <= RUN;
            end
          end
        end
        RUN: begin
          r_rem      <= w_rem_next;
          r_quot     <= w_quot_next;
          r_dividend <= {r_dividend[30:0], 1'b0};
          r_count    <= r_count + 5'd1;
          // Count 31 marks the 32nd iteration: commit results directly from
          // the step logic so HI/LO change only on the edge entering DONE.
          if (r_count == 5'd31) begin
            r_hi    <= w_rem_next;
            r_lo    <= w_quot_next;
            r_dbz   <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign dbz  = r_dbz;

  always_comb begin
    dataOut = 32'd0;
    if (Signal == MFHI) begin
      dataOut = r_hi;
    end else if (Signal == MFLO) begin
      dataOut = r_lo;
    end
  end

endmodule
`default_nettype wire

// File: doc/divu_hilo.md
DIVU_HILO -- requirements
Module: divu_hilo

Interface
REQ-001 Parameter DIVU, default 6'b011011, function code that starts an unsigned divide.
REQ-002 Parameter MFHI, default 6'b010000, function code that selects HI onto dataOut.
REQ-003 Parameter MFLO, default 6'b010010, function code that selects LO onto dataOut.
REQ-004 Port clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port Signal  input  6  function code from the ALU control stage.
REQ-007 Port dataA  input  32  dividend (unsigned).
REQ-008 Port dataB  input  32  divisor (unsigned).
REQ-009 Port dataOut  output  32  HI or LO read data.
REQ-010 Port busy  output  1  high while a divide is iterating.
REQ-011 Port done  output  1  one-cycle pulse when HI/LO have been written.
REQ-012 Port dbz  output  1  divide-by-zero flag, valid with done.

Function
REQ-013 The block SHALL have states IDLE, RUN and DONE, and SHALL register prevSignal (the previous-cycle Signal).
REQ-014 Start condition: state==IDLE, Signal==DIVU and prevSignal!=DIVU; a DIVU held over many cycles SHALL start exactly one divide.
REQ-015 At the start edge with dataB!=0: latch dividend and divisor, clear remainder and count, go to RUN.
REQ-016 At the start edge with dataB==0: HI<=dataA, LO<=32'hFFFFFFFF, dbz<=1, go to DONE with no iterations.
REQ-017 In RUN, each edge SHALL perform one restoring shift-subtract step: remainder shifts left by 1 and takes the dividend MSB; dividend shifts left by 1. If the 33-bit remainder is >= divisor, subtract the divisor and set the quotient LSB to 1; otherwise set it to 0. count increments.
REQ-018 On the 32nd RUN edge: HI<=final remainder, LO<=quotient, dbz<=0, go to DONE; start edge to done high = 33 edges.
REQ-019 done SHALL be 1 only in DONE, which SHALL last exactly one cycle; the next state is always IDLE.
REQ-020 busy SHALL be 1 only in RUN.
REQ-021 Start requests (Signal==DIVU) seen in RUN or DONE SHALL be ignored and not queued.
REQ-022 dataA/dataB changes after the start edge SHALL NOT affect the result.
REQ-023 dataOut SHALL be combinational: HI if Signal==MFHI, LO if Signal==MFLO, otherwise 32'h0.
REQ-024 While busy, dataOut SHALL return the previous HI/LO; in the DONE cycle it SHALL return the new values.
REQ-025 HI and LO SHALL change only at the edge that enters DONE.

Reset
REQ-026 When reset is asserted, the block SHALL immediately set state=IDLE, HI=LO=0, prevSignal=0, count=0, busy=0, done=0 and dbz=0, regardless of the clock.
REQ-027 A reset during RUN SHALL abort the divide with no HI/LO update; after release, a new start SHALL need a fresh DIVU edge per REQ-014.

Verification
REQ-028 Scenario: dataA=100, dataB=7, Signal->DIVU for 1 cycle -> busy for 32 cycles, done at edge 33, then MFHI gives 2 and MFLO gives 14.
REQ-029 Scenario: dataA=32'hFFFFFFFF, dataB=1 -> LO=32'hFFFFFFFF, HI=0, dbz=0.
REQ-030 Scenario: dataA=5, dataB=0 -> done on the edge after start, busy never high, HI=5, LO=32'hFFFFFFFF, dbz=1.
REQ-031 Scenario: Signal held at DIVU for 80 cycles with dataA=9, dataB=4 -> exactly one done pulse; HI=1, LO=2.
REQ-032 Scenario: reset pulsed at RUN cycle 10 with prior HI=3, LO=4 -> busy=0 and done=0 immediately; MFHI/MFLO give 0/0; no done follows.
REQ-033 Scenario: dataA=6, dataB=3 result in HI/LO; start 50/8; MFLO every cycle during RUN -> reads 2 until DONE, then 6; HI=2.
